// File: rtl/fetch_unit_pkg.sv
// Shared core constants for the instruction fetch path: reset vector, NOP word,
// fetch FSM encoding and the prefetch buffer entry layout.
package fetch_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IMEM_AW = 14;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with synchronous flush.
// The producer never pushes into a full buffer unless it also pops.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  fetch_entry_t  wr_entry,
    output fetch_entry_t  rd_entry,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop = pop && (count_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_entry;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

    assign rd_entry = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential prefetch into a small buffer, with
// redirect (flush + restart) and halt control over a 1-cycle-latency IMEM.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               halt,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [XLEN-1:0]    inst_data,
    output logic [XLEN-1:0]    inst_pc,
    output logic               inst_misaligned
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic [XLEN-1:0] issue_pc;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            pop;
    logic            push;
    logic            room;
    logic            issue;

    // A redirect flushes the buffer and kills the response, so it always has room.
    assign pop   = inst_valid && inst_ready && !redirect_valid;
    assign push  = inflight_q && !redirect_valid;
    assign room  = redirect_valid
                || ((SW'(count) + SW'(inflight_q)) < (SW'(DEPTH) + SW'(pop)));
    assign issue = reset_n && (state_q == ST_RUN) && !halt && room;

    assign issue_pc  = redirect_valid ? redirect_pc : fetch_pc_q;
    assign imem_req  = issue;
    assign imem_addr = issue_pc[IMEM_AW-1:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (issue) begin
            fetch_pc_d = issue_pc + 32'd4;
        end else if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q    <= halt ? ST_HALTED : ST_RUN;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= issue_pc;
            end
        end
    end

    assign push_entry = '{data:       imem_rdata,
                          pc:         inflight_pc_q,
                          misaligned: is_misaligned(inflight_pc_q)};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect_valid),
        .push     (push),
        .pop      (pop),
        .wr_entry (push_entry),
        .rd_entry (head),
        .count    (count)
    );

    assign inst_valid      = (count != '0);
    assign inst_data       = head.data;
    assign inst_pc         = head.pc;
    assign inst_misaligned = head.misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/halt/redirect traffic,
// checked against an instruction-stream scoreboard and a fetch-address model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_misaligned;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_misaligned (inst_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] ram_word(input logic [13:0] a);
        return 32'h0050_0093 ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endfunction

    // Instruction RAM with one-cycle read latency; junk on idle cycles.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= ram_word(imem_addr);
        else          imem_rdata <= $urandom;
    end

    // Expected stream after a restart: sequential words from pc onward.
    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_t e;
            e.pc   = pc + 32'(4 * i);
            e.data = ram_word(e.pc[13:0]);
            e.mis  = (e.pc[1:0] != 2'b00);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: stream scoreboard, fetch address order, capacity and halt rules.
    logic [31:0] mon_fetch;
    int          outstanding;
    int          stall;
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("reset_ctrl", {29'd0, imem_req, inst_valid, inst_misaligned}, 32'd0);
            chk("reset_data", inst_data, 32'd0);
            chk("reset_pc", inst_pc, 32'd0);
            mon_fetch   = RST_PC;
            outstanding = 0;
            stall       = 0;
        end else begin
            if (redirect_valid) begin
                mon_fetch   = redirect_pc;
                outstanding = 0;
            end
            if (halt) chk("halt_no_req", {31'd0, imem_req}, 32'd0);
            if (imem_req) begin
                chk("fetch_addr", {18'd0, imem_addr}, {18'd0, mon_fetch[13:0]});
                mon_fetch = mon_fetch + 32'd4;
                outstanding++;
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("stream_pc", inst_pc, e.pc);
                    chk("stream_data", inst_data, e.data);
                    chk("stream_mis", {31'd0, inst_misaligned}, {31'd0, e.mis});
                end
                outstanding--;
                stall = 0;
            end else if (!inst_ready || halt || redirect_valid) begin
                stall = 0;
            end else begin
                stall++;
            end
            if (imem_req) chk("capacity", {31'd0, outstanding > int'(DEPTH)}, 32'd0);
            if (stall > 8) begin
                chk("progress", 32'(stall), 32'd0);
                stall = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_and_check();
        @(posedge clk); #1;
        reset_n = 1'b1;
        restart(RST_PC);
        @(negedge clk);
        chk("rel_req0", {31'd0, imem_req}, 32'd1);
        chk("rel_addr0", {18'd0, imem_addr}, 32'h0000);
        @(negedge clk);
        chk("rel_addr1", {18'd0, imem_addr}, 32'h0004);
        @(negedge clk);
        chk("rel_addr2", {18'd0, imem_addr}, 32'h0008);
        chk("rel_valid", {31'd0, inst_valid}, 32'd1);
        chk("rel_pc", inst_pc, RST_PC);
        chk("rel_data", inst_data, 32'h0050_0093);
    endtask

    task automatic redirect_check(input logic [31:0] pc, input string tag);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        inst_ready     = 1'b1;
        restart(pc);
        @(negedge clk);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, {18'd0, imem_addr}, {18'd0, pc[13:0]});
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_valid_n2"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_pc_n2"}, inst_pc, pc);
        chk({tag, "_mis_n2"}, {31'd0, inst_misaligned}, {31'd0, pc[1:0] != 2'b00});
        @(negedge clk);
        chk({tag, "_pc_n3"}, inst_pc, pc + 32'd4);
    endtask

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        inst_ready     = 1'b1;
        cyc(3);

        release_and_check();

        // Backpressure: buffer saturates and fetching stops.
        cyc(3);
        inst_ready = 1'b0;
        cyc(10);
        @(negedge clk);
        chk("bp_valid", {31'd0, inst_valid}, 32'd1);
        chk("bp_no_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        inst_ready = 1'b1;
        cyc(6);

        // Redirect with a full buffer and a request in flight.
        inst_ready = 1'b0;
        cyc(3);
        inst_ready = 1'b1;
        redirect_check(32'h8000_0100, "redir");
        cyc(4);

        // Halt: issue stops, buffer drains, then sequential resume.
        halt = 1'b1;
        repeat (5) @(negedge clk);
        chk("halt_drained", {31'd0, inst_valid}, 32'd0);
        @(posedge clk); #1;
        halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("halt_resume_req", {31'd0, imem_req}, 32'd1);
        cyc(4);

        redirect_check(32'h8000_0102, "misal");
        cyc(4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            inst_ready     = ($urandom_range(0, 9) < 7);
            halt           = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if (redirect_valid) begin
                redirect_pc = $urandom;
                restart(redirect_pc);
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        inst_ready     = 1'b1;
        cyc(5);

        // Asynchronous reset mid-stream with a request in flight.
        @(posedge clk);
        #3;
        chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_ctrl", {29'd0, imem_req, inst_valid, inst_misaligned}, 32'd0);
        chk("async_data", inst_data, 32'd0);
        chk("async_pc", inst_pc, 32'd0);
        cyc(2);
        release_and_check();
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, prefetch buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port redirect_valid  input  1  core requests a fetch-stream restart (jump/branch taken).
REQ-006 SHALL have port redirect_pc  input  32  restart address.
REQ-007 SHALL have port halt  input  1  stop issuing new fetches while high.
REQ-008 SHALL have port imem_req  output  1  instruction-memory read strobe.
REQ-009 SHALL have port imem_addr  output  14  byte address to instruction RAM, pc[13:0].
REQ-010 SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after imem_req.
REQ-011 SHALL have port inst_valid  output  1  buffer head holds an instruction.
REQ-012 SHALL have port inst_ready  input  1  core consumes head this cycle.
REQ-013 SHALL have port inst_data  output  32  head instruction word.
REQ-014 SHALL have port inst_pc  output  32  address of head instruction.
REQ-015 SHALL have port inst_misaligned  output  1  head pc has bits[1:0] != 0.

Function
REQ-016 SHALL hold fetch_pc, buffer (DEPTH x {data, pc, misaligned}), count, one in-flight flag and its pc.
REQ-017 SHALL issue imem_req when state RUN and count + inflight - pop < DEPTH, where pop = inst_valid & inst_ready.
REQ-018 SHALL drive imem_addr = redirect_valid ? redirect_pc[13:0] : fetch_pc[13:0] combinationally.
REQ-019 SHALL advance fetch_pc to issued address + 4 on every issued request (32-bit wrap).
REQ-020 SHALL push {imem_rdata, inflight_pc, inflight_pc[1:0]!=0} into the buffer the cycle after a request, unless killed.
REQ-021 SHALL, when buffer empty and inst_ready low, still accept the push; no data is ever dropped except by redirect.
REQ-022 SHALL allow push and pop in the same cycle at any count, count unchanged, including count == DEPTH.
REQ-023 SHALL present buffer head on inst_data/inst_pc/inst_misaligned with inst_valid = (count != 0); no bypass of imem_rdata to outputs.
REQ-024 SHALL on redirect_valid: clear the buffer, kill any in-flight response, issue imem_req at redirect_pc the same cycle (if not halted), fetch_pc <= redirect_pc + 4.
REQ-025 SHALL give redirect latency: redirect at cycle N -> inst_valid with inst_pc = redirect_pc at cycle N+2.
REQ-026 SHALL ignore inst_ready in the redirect cycle (pop suppressed, buffer flushed).
REQ-027 SHALL implement FSM states RUN and HALTED: RUN->HALTED when halt=1; HALTED->RUN when halt=0; halt dominates redirect for issue, but redirect still flushes and loads fetch_pc.
REQ-028 SHALL, in HALTED, let an in-flight response complete and let the core drain the buffer.
REQ-029 SHALL flag misaligned redirect_pc via inst_misaligned and keep fetching sequentially from it; trapping is the core's job.

Reset
REQ-030 SHALL on reset_n low asynchronously set fetch_pc=RESET_PC, count=0, inflight=0, state=RUN.
REQ-031 SHALL drive imem_req=0, inst_valid=0, inst_misaligned=0, inst_data=0, inst_pc=0 during reset.
REQ-032 SHALL issue first imem_req at RESET_PC on the first rising edge-cycle after reset_n deasserts; a response pending at reset assertion is discarded.

Structure
REQ-033 SHALL take RESET_PC default, NOP word 32'h00000013 and FSM state encodings from a shared core constants package.
REQ-034 SHALL contain one sub-module, fetch_fifo (parameterised DEPTH, synchronous flush, push/pop/count).
REQ-035 SHALL be 120-400 lines of RTL total, no latches, no combinational path from imem_rdata to any output.

Verification
REQ-036 Reset release, inst_ready=1, RAM holds 0x00500093 at 0x0 -> imem_addr 0x0000, 0x0004, 0x0008 on consecutive cycles; inst_pc 0x80000000 valid two cycles after release.
REQ-037 inst_ready=0 for 10 cycles -> count saturates at 2, imem_req low, no request issued beyond capacity; releasing ready yields pcs in order with no gap/duplicate.
REQ-038 Redirect to 0x80000100 while buffer full and request in flight -> stale words never appear; next inst_pc 0x80000100 at N+2, then 0x80000104.
REQ-039 halt=1 for 5 cycles -> imem_req low after current request; buffer drains; halt=0 resumes at next sequential pc.
REQ-040 Redirect to 0x80000102 -> inst_misaligned=1 with inst_pc 0x80000102, next 0x80000106.
REQ-041 reset_n asserted mid-stream with request in flight -> outputs zero immediately (async); after release fetch restarts at 0x80000000.
